// File: rtl/pin_ident_sequencer.sv
// Pin identification sequencer: every frame each channel blinks its row code, then its column code,
// so a header pin can be mapped to its package ball by eye or with a logic analyser.
module pin_ident_sequencer #(
    parameter int unsigned NUM_CH          = 8,
    parameter int unsigned IDX_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int unsigned TICK_DIV        = 2500000,
    parameter int unsigned GAP_TICKS       = 8,
    parameter int unsigned FRAME_GAP_TICKS = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [1:0]          mode_i,
    input  logic [5*NUM_CH-1:0] row_code_i,
    input  logic [5*NUM_CH-1:0] col_code_i,
    output logic [NUM_CH-1:0]   ch_o,
    output logic [IDX_W-1:0]    walk_idx_o,
    output logic                frame_stb_o,
    output logic                walk_stb_o
);
    localparam int unsigned CODE_W      = 5;
    localparam int unsigned PHASE_TICKS = 62;
    localparam int unsigned GAP_MAX     = (GAP_TICKS > FRAME_GAP_TICKS) ? GAP_TICKS : FRAME_GAP_TICKS;
    localparam int unsigned SEG_MAX     = (GAP_MAX > PHASE_TICKS) ? GAP_MAX : PHASE_TICKS;
    localparam int unsigned TCNT_W      = $clog2(SEG_MAX);
    localparam int unsigned DIV_W       = $clog2(TICK_DIV);

    localparam logic [1:0] MODE_IDENT   = 2'd0;
    localparam logic [1:0] MODE_ALL_ON  = 2'd1;
    localparam logic [1:0] MODE_WALK    = 2'd2;
    localparam logic [1:0] MODE_ALL_OFF = 2'd3;

    typedef enum logic [1:0] {ST_ROW, ST_GAP1, ST_COL, ST_GAP2} state_t;

    state_t                state_q, state_d;
    logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  armed_q, armed_d;
    logic [1:0]            mode_q, mode_d;
    logic [5*NUM_CH-1:0]   row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]      walk_idx_d;
    logic [NUM_CH-1:0]     ch_d, pat, walk_sel;
    logic                  frame_stb_d, walk_stb_d;
    logic                  tick, frame_start, pulse_slot;
    logic [CODE_W-1:0]     slot, code;

    // Next-state: tick divider, frame position, latching at frame start and pin pattern
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        div_d       = div_q;
        armed_d     = armed_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        walk_idx_d  = walk_idx_o;
        ch_d        = ch_o;
        frame_stb_d = 1'b0;
        walk_stb_d  = 1'b0;
        tick        = 1'b0;
        frame_start = 1'b0;
        pulse_slot  = 1'b0;
        slot        = '0;
        code        = '0;
        pat         = '0;
        walk_sel    = '0;

        if (!en_i) begin
            state_d = ST_ROW;
            tcnt_d  = '0;
            div_d   = '0;
            armed_d = 1'b0;
            ch_d    = '0;
        end else begin
            tick  = (div_q == DIV_W'(TICK_DIV - 1));
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                // An unarmed sequencer (after reset or enable) starts a fresh frame on its first tick
                if (!armed_q) begin
                    frame_start = 1'b1;
                    state_d     = ST_ROW;
                    tcnt_d      = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    case (state_q)
                        ST_ROW: if (tcnt_q == TCNT_W'(PHASE_TICKS - 1)) begin
                            state_d = ST_GAP1;
                            tcnt_d  = '0;
                        end
                        ST_GAP1: if (tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
                            state_d = ST_COL;
                            tcnt_d  = '0;
                        end
                        ST_COL: if (tcnt_q == TCNT_W'(PHASE_TICKS - 1)) begin
                            state_d = ST_GAP2;
                            tcnt_d  = '0;
                        end
                        ST_GAP2: if (tcnt_q == TCNT_W'(FRAME_GAP_TICKS - 1)) begin
                            state_d     = ST_ROW;
                            tcnt_d      = '0;
                            frame_start = 1'b1;
                        end
                        default: begin
                            state_d = ST_ROW;
                            tcnt_d  = '0;
                        end
                    endcase
                end
                armed_d = 1'b1;

                if (frame_start) begin
                    mode_d      = mode_i;
                    row_d       = row_code_i;
                    col_d       = col_code_i;
                    frame_stb_d = 1'b1;
                    if (mode_q == MODE_WALK && mode_i == MODE_WALK) begin
                        walk_idx_d = (walk_idx_o == IDX_W'(NUM_CH - 1)) ? '0 : walk_idx_o + IDX_W'(1);
                        walk_stb_d = 1'b1;
                    end
                end

                // Pulse in slot s = t/2 on even ticks while s is below the channel's code
                pulse_slot = (state_d == ST_ROW || state_d == ST_COL) && !tcnt_d[0];
                slot       = tcnt_d[CODE_W:1];
                for (int k = 0; k < int'(NUM_CH); k++) begin
                    code   = (state_d == ST_ROW) ? row_d[CODE_W*k +: CODE_W] : col_d[CODE_W*k +: CODE_W];
                    pat[k] = pulse_slot && (slot < code);
                end
                walk_sel = NUM_CH'(1) << walk_idx_d;

                case (mode_d)
                    MODE_IDENT:   ch_d = pat;
                    MODE_ALL_ON:  ch_d = '1;
                    MODE_WALK:    ch_d = pat & walk_sel;
                    MODE_ALL_OFF: ch_d = '0;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ROW;
            tcnt_q      <= '0;
            div_q       <= '0;
            armed_q     <= 1'b0;
            mode_q      <= MODE_IDENT;
            row_q       <= '0;
            col_q       <= '0;
            walk_idx_o  <= '0;
            ch_o        <= '0;
            frame_stb_o <= 1'b0;
            walk_stb_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            div_q       <= div_d;
            armed_q     <= armed_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            walk_idx_o  <= walk_idx_d;
            ch_o        <= ch_d;
            frame_stb_o <= frame_stb_d;
            walk_stb_o  <= walk_stb_d;
        end
    end

endmodule
